cfa_window_scanner: RTL and testbench

- Next-generation raster address generator with an integrated CFA colour tagger.
- Scans a configurable image from (0,0) to (rowMax,colMax) and emits one memory address per accepted beat, with row/col, a CFA colour symbol and a window-valid flag for the downstream line-buffer/filter stage.
- Adds over the previous generation: a valid/ready output handshake, a Quad-Bayer (4x4) CFA mode, per-frame configuration latching, window-valid generation for any odd FILTER_SIZE, and configuration-error detection.

---
 rtl/cfa_pkg.sv | 47 ++++
 rtl/cfa_symbol_map.sv | 22 ++
 rtl/cfa_window_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_cfa_window_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA window scanner.
// Holds the colour-symbol, pattern and mode encodings, the scanner state
// enum and the symbol-mapping helper used by cfa_symbol_map.
package cfa_pkg;

  // Colour symbols presented on bayerSymbol
  localparam logic [1:0] CFA_R  = 2'd0;
  localparam logic [1:0] CFA_GR = 2'd1;
  localparam logic [1:0] CFA_GB = 2'd2;
  localparam logic [1:0] CFA_B  = 2'd3;

  // Pattern selector encodings (colour of the top-left pixel pair)
  localparam logic [1:0] PAT_RGGB = 2'd0;
  localparam logic [1:0] PAT_GRBG = 2'd1;
  localparam logic [1:0] PAT_GBRG = 2'd2;
  localparam logic [1:0] PAT_BGGR = 2'd3;

  // CFA tiling modes
  localparam logic CFA_BAYER = 1'b0;
  localparam logic CFA_QUAD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Quad-Bayer repeats each colour over a 2x2 block, so the colour toggles
  // on bit 1 of the coordinate instead of bit 0. The pattern bits simply
  // flip the row/col phase of the tile.
  function automatic logic [1:0] cfa_symbol(input logic [1:0] row_bits,
                                            input logic [1:0] col_bits,
                                            input logic [1:0] pattern,
                                            input logic       mode);
    logic row_ph;
    logic col_ph;
    if (mode == CFA_QUAD) begin
      row_ph = row_bits[1];
      col_ph = col_bits[1];
    end else begin
      row_ph = row_bits[0];
      col_ph = col_bits[0];
    end
    return {row_ph ^ pattern[1], col_ph ^ pattern[0]};
  endfunction

endpackage

// File: rtl/cfa_symbol_map.sv
// Combinational CFA colour tagger.
// Ports:
//   row_bits, col_bits : low two bits of the pixel coordinate
//   pattern            : pattern selector (PAT_*)
//   mode               : CFA_BAYER or CFA_QUAD
//   symbol             : colour symbol (CFA_*); the parent registers it
module cfa_symbol_map
  import cfa_pkg::*;
(
  input  logic [1:0] row_bits,
  input  logic [1:0] col_bits,
  input  logic [1:0] pattern,
  input  logic       mode,
  output logic [1:0] symbol
);

  // Map coordinate phase and pattern to the colour symbol
  always_comb begin
    symbol = cfa_symbol(row_bits, col_bits, pattern, mode);
  end

endmodule

// File: rtl/cfa_window_scanner.sv
// Raster address generator with CFA colour tagging and window-valid flag.
// Scans (0,0)..(rowMax,colMax) of a frame, emitting one linear address per
// accepted beat together with row/col, colour symbol and windowValid.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, en           : frame start request, global advance enable
//   rowMax, colMax      : last row/col index (signed, latched on start)
//   patternSelect       : CFA pattern (latched on start)
//   cfaMode             : Bayer / Quad-Bayer (latched on start)
//   outReady            : downstream accepts the current beat
//   address,row,col     : current beat coordinates (registered)
//   bayerSymbol         : colour of the current beat (registered)
//   windowValid         : current beat has a full FILTER_SIZE window behind it
//   addrValid           : beat outputs are valid
//   bufferEnable        : line-buffer write strobe (accepted beat)
//   rowUpdateFlag       : accepted beat is the last column of its row
//   colUpdateFlag       : accepted beat
//   ready, done         : idle indicator, end-of-frame pulse
//   cfgError            : pulse together with done for a rejected frame size
module cfa_window_scanner
  import cfa_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int ROW_W       = 11,
  parameter int COL_W       = 11,
  parameter int FILTER_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic signed [ROW_W-1:0] rowMax,
  input  logic signed [COL_W-1:0] colMax,
  input  logic [1:0]              patternSelect,
  input  logic                    cfaMode,
  input  logic                    outReady,
  output logic [ADDR_W-1:0]       address,
  output logic                    addrValid,
  output logic [ROW_W-1:0]        row,
  output logic [COL_W-1:0]        col,
  output logic [1:0]              bayerSymbol,
  output logic                    windowValid,
  output logic                    bufferEnable,
  output logic                    rowUpdateFlag,
  output logic                    colUpdateFlag,
  output logic                    ready,
  output logic                    done,
  output logic                    cfgError
);

  // Smallest legal bound, signed so negative bounds are rejected too
  localparam logic signed [ROW_W-1:0] ROW_LIM = ROW_W'(FILTER_SIZE - 32'sd1);
  localparam logic signed [COL_W-1:0] COL_LIM = COL_W'(FILTER_SIZE - 32'sd1);
  // Same constants as unsigned thresholds for the (never negative) counters
  localparam logic [ROW_W-1:0] ROW_WIN = ROW_W'(FILTER_SIZE - 32'sd1);
  localparam logic [COL_W-1:0] COL_WIN = COL_W'(FILTER_SIZE - 32'sd1);

  state_t             state_r, state_nxt_s;
  logic [ROW_W-1:0]   row_max_r, row_max_nxt_s;
  logic [COL_W-1:0]   col_max_r, col_max_nxt_s;
  logic [1:0]         pat_r, pat_nxt_s;
  logic               mode_r, mode_nxt_s;
  logic               err_r, err_nxt_s;
  logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
  logic [ROW_W-1:0]   row_r, row_nxt_s;
  logic [COL_W-1:0]   col_r, col_nxt_s;
  logic [1:0]         sym_r, sym_nxt_s;
  logic               win_r, win_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               done_r, done_nxt_s;
  logic               cfg_err_r, cfg_err_nxt_s;

  logic               cfg_bad_s;
  logic               col_wrap_s;
  logic               last_s;
  logic               fire_s;

  assign cfg_bad_s  = (rowMax < ROW_LIM) || (colMax < COL_LIM);
  assign col_wrap_s = (col_r == col_max_r);
  assign last_s     = col_wrap_s && (row_r == row_max_r);
  assign fire_s     = valid_r && outReady && en;

  // Symbol is looked up for the coordinate being loaded so it stays aligned
  cfa_symbol_map u_symbol_map (
    .row_bits (row_nxt_s[1:0]),
    .col_bits (col_nxt_s[1:0]),
    .pattern  (pat_nxt_s),
    .mode     (mode_nxt_s),
    .symbol   (sym_nxt_s)
  );

  // Window flag for the coordinate being loaded, against fixed thresholds
  always_comb begin
    win_nxt_s = (row_nxt_s >= ROW_WIN) && (col_nxt_s >= COL_WIN);
  end

  // Next-state and next-output logic of the scan controller
  always_comb begin
    state_nxt_s   = state_r;
    row_max_nxt_s = row_max_r;
    col_max_nxt_s = col_max_r;
    pat_nxt_s     = pat_r;
    mode_nxt_s    = mode_r;
    err_nxt_s     = err_r;
    addr_nxt_s    = addr_r;
    row_nxt_s     = row_r;
    col_nxt_s     = col_r;
    valid_nxt_s   = valid_r;
    ready_nxt_s   = ready_r;
    done_nxt_s    = 1'b0;
    cfg_err_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          row_max_nxt_s = rowMax;
          col_max_nxt_s = colMax;
          pat_nxt_s     = patternSelect;
          mode_nxt_s    = cfaMode;
          ready_nxt_s   = 1'b0;
          if (cfg_bad_s) begin
            // Rejected frame: no beats, report on the way out
            err_nxt_s   = 1'b1;
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_FINISH;
          end else begin
            err_nxt_s   = 1'b0;
            valid_nxt_s = 1'b1;
            addr_nxt_s  = {ADDR_W{1'b0}};
            row_nxt_s   = {ROW_W{1'b0}};
            col_nxt_s   = {COL_W{1'b0}};
            state_nxt_s = ST_SCAN;
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end

      ST_SCAN: begin
        if (valid_r && outReady) begin
          if (last_s) begin
            // Final beat accepted; coordinates hold their last value
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_FINISH;
          end else if (col_wrap_s) begin
            col_nxt_s  = {COL_W{1'b0}};
            row_nxt_s  = row_r + ROW_W'(1'b1);
            addr_nxt_s = addr_r + ADDR_W'(1'b1);
          end else begin
            col_nxt_s  = col_r + COL_W'(1'b1);
            addr_nxt_s = addr_r + ADDR_W'(1'b1);
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end

      ST_FINISH: begin
        done_nxt_s    = 1'b1;
        cfg_err_nxt_s = err_r;
        err_nxt_s     = 1'b0;
        ready_nxt_s   = 1'b1;
        state_nxt_s   = ST_IDLE;
      end

      default: begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; en low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      row_max_r <= {ROW_W{1'b0}};
      col_max_r <= {COL_W{1'b0}};
      pat_r     <= 2'd0;
      mode_r    <= 1'b0;
      err_r     <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      row_r     <= {ROW_W{1'b0}};
      col_r     <= {COL_W{1'b0}};
      sym_r     <= 2'd0;
      win_r     <= 1'b0;
      valid_r   <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else if (en) begin
      state_r   <= state_nxt_s;
      row_max_r <= row_max_nxt_s;
      col_max_r <= col_max_nxt_s;
      pat_r     <= pat_nxt_s;
      mode_r    <= mode_nxt_s;
      err_r     <= err_nxt_s;
      addr_r    <= addr_nxt_s;
      row_r     <= row_nxt_s;
      col_r     <= col_nxt_s;
      sym_r     <= sym_nxt_s;
      win_r     <= win_nxt_s;
      valid_r   <= valid_nxt_s;
      ready_r   <= ready_nxt_s;
      done_r    <= done_nxt_s;
      cfg_err_r <= cfg_err_nxt_s;
    end
  end

  assign address       = addr_r;
  assign addrValid     = valid_r;
  assign row           = row_r;
  assign col           = col_r;
  assign bayerSymbol   = sym_r;
  assign windowValid   = win_r;
  assign ready         = ready_r;
  assign done          = done_r;
  assign cfgError      = cfg_err_r;
  // Strobes follow the live handshake so they mark the accepted beat itself
  assign bufferEnable  = fire_s;
  assign colUpdateFlag = fire_s;
  assign rowUpdateFlag = fire_s && col_wrap_s;

endmodule

// File: tb/tb_cfa_window_scanner.sv
// Self-checking bench for cfa_window_scanner: randomized handshakes checked
// against a frame model computed from row/col arithmetic.
module tb_cfa_window_scanner;

  localparam int ADDR_W = 17;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 11;
  localparam int FS     = 5;

  logic                    clk = 1'b0;
  logic                    rst, start, en, outReady, cfaMode;
  logic signed [ROW_W-1:0] rowMax;
  logic signed [COL_W-1:0] colMax;
  logic [1:0]              patternSelect;
  logic [ADDR_W-1:0]       address;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [1:0]              bayerSymbol;
  logic addrValid, windowValid, bufferEnable, rowUpdateFlag, colUpdateFlag;
  logic ready, done, cfgError;

  int tests = 0;
  int fails = 0;

  typedef logic [48:0] obs_t;
  obs_t       obs;
  logic [6:0] ctl;

  assign obs = {addrValid, address, row, col, bayerSymbol, windowValid,
                bufferEnable, rowUpdateFlag, colUpdateFlag, ready, done, cfgError};
  assign ctl = {addrValid, bufferEnable, rowUpdateFlag, colUpdateFlag, ready, done, cfgError};

  cfa_window_scanner #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W), .FILTER_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .rowMax(rowMax), .colMax(colMax),
    .patternSelect(patternSelect), .cfaMode(cfaMode), .outReady(outReady),
    .address(address), .addrValid(addrValid), .row(row), .col(col),
    .bayerSymbol(bayerSymbol), .windowValid(windowValid), .bufferEnable(bufferEnable),
    .rowUpdateFlag(rowUpdateFlag), .colUpdateFlag(colUpdateFlag),
    .ready(ready), .done(done), .cfgError(cfgError)
  );

  always #5 clk = ~clk;

  // Expected outputs while presenting beat n of a (R+1)x(C+1) frame
  function automatic obs_t beat_exp(int n, int R, int C, logic [1:0] pat, logic mode, logic fire);
    int r, c, d;
    logic [1:0] sym;
    logic [ADDR_W-1:0] a;
    r = n / (C + 1);
    c = n % (C + 1);
    d = mode ? 2 : 1;
    sym[1] = (((r / d) % 2) != 0) ^ pat[1];
    sym[0] = (((c / d) % 2) != 0) ^ pat[0];
    a = ADDR_W'(n);
    return {1'b1, a, ROW_W'(r), COL_W'(c), sym, (r >= FS - 1) && (c >= FS - 1),
            fire, fire && (c == C), fire, 1'b0, 1'b0, 1'b0};
  endfunction

  // Run one frame: random outReady/en, optional mid-frame pokes, en gap on last beat
  task automatic run_frame(input string name, input int R, input int C, input logic [1:0] pat,
                           input logic mode, input int rdy_pct, input int en_pct,
                           input bit poke, input int en_gap);
    int   beat, cyc, total, gap;
    logic fire;
    obs_t exp;
    beat = 0; cyc = 0; total = (R + 1) * (C + 1); gap = en_gap;
    rowMax = ROW_W'(R); colMax = COL_W'(C); patternSelect = pat; cfaMode = mode;
    en = 1'b1; outReady = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (beat < total && cyc < 4000) begin
      outReady = ($urandom_range(99) < rdy_pct);
      en = ($urandom_range(99) < en_pct);
      if (beat == total - 1 && gap > 0) begin
        en = 1'b0;
        gap--;
      end
      if (poke && beat == 10) begin
        start = 1'b1; rowMax = 11'sd1; colMax = 11'sd4;
        patternSelect = ~pat; cfaMode = ~mode;
      end
      #3;
      fire = outReady && en;
      exp = beat_exp(beat, R, C, pat, mode, fire);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s beat %0d: got %h want %h", name, beat, obs, exp);
      end
      if (fire) beat++;
      cyc++;
      @(posedge clk); #1; start = 1'b0;
    end
    tests++;
    if (beat !== total) begin
      fails++;
      $display("FAIL %s beat_count: got %0d want %0d", name, beat, total);
    end
    if (rdy_pct >= 100 && en_pct >= 100) begin
      tests++;
      if (cyc !== total + en_gap) begin
        fails++;
        $display("FAIL %s cycles: got %0d want %0d", name, cyc, total + en_gap);
      end
    end
    en = 1'b1; outReady = 1'($urandom_range(1)); #3;
    tests++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("FAIL %s finish_state: got %b want %b", name, ctl, 7'b0000000);
    end
    @(posedge clk); #4;
    tests++;
    if (ctl !== 7'b0000110) begin
      fails++;
      $display("FAIL %s done_pulse: got %b want %b", name, ctl, 7'b0000110);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; en = 1'b1; outReady = 1'b1;
    rowMax = 11'sd5; colMax = 11'sd7; patternSelect = 2'd0; cfaMode = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    tests++;
    if (obs !== 49'h4) begin
      fails++;
      $display("FAIL reset_values: got %h want %h", obs, 49'h4);
    end
    @(posedge clk); #1; rst = 1'b0; #3;
  endtask

  task automatic test_basic();
    run_frame("bayer_rggb", 5, 7, 2'd0, 1'b0, 100, 100, 1'b0, 0);
  endtask

  task automatic test_quad();
    run_frame("quad_gbrg", 5, 7, 2'd2, 1'b1, 100, 100, 1'b0, 0);
  endtask

  task automatic test_stall();
    run_frame("stall", 5, 7, 2'($urandom_range(3)), 1'($urandom_range(1)), 45, 100, 1'b0, 0);
  endtask

  task automatic test_cfg_error(input string name, input int R, input int C);
    rowMax = ROW_W'(R); colMax = COL_W'(C); start = 1'b1; en = 1'b1;
    @(posedge clk); #1; start = 1'b0; #3;
    tests++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("FAIL %s no_beats: got %b want %b", name, ctl, 7'b0000000);
    end
    @(posedge clk); #4;
    tests++;
    if (ctl !== 7'b0000111) begin
      fails++;
      $display("FAIL %s err_pulse: got %b want %b", name, ctl, 7'b0000111);
    end
    @(posedge clk); #4;
    tests++;
    if (ctl !== 7'b0000100) begin
      fails++;
      $display("FAIL %s pulse_end: got %b want %b", name, ctl, 7'b0000100);
    end
  endtask

  task automatic test_reset_midframe();
    rowMax = 11'sd7; colMax = 11'sd9; patternSelect = 2'd1; cfaMode = 1'b0;
    en = 1'b1; outReady = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #4;
    tests++;
    if (addrValid !== 1'b1 || address !== 17'd20) begin
      fails++;
      $display("FAIL midframe_beat20: got %b/%0d want 1/20", addrValid, address);
    end
    rst = 1'b1; #1;
    tests++;
    if (obs !== 49'h4) begin
      fails++;
      $display("FAIL async_reset: got %h want %h", obs, 49'h4);
    end
    @(posedge clk); #1; rst = 1'b0; #3;
    run_frame("restart", 7, 9, 2'd1, 1'b0, 100, 100, 1'b0, 0);
  endtask

  task automatic test_mid_frame_changes();
    run_frame("ignore_start_gap", 5, 7, 2'd3, 1'b0, 100, 100, 1'b1, 3);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 4, 4, 2'd1, 1'b1, 100, 100, 1'b0, 0);
    run_frame("b2b_b", 4, 5, 2'd2, 1'b0, 70, 100, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_frame("random", $urandom_range(9, 4), $urandom_range(12, 4),
                2'($urandom_range(3)), 1'($urandom_range(1)), 60, 85, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quad();
    test_stall();
    test_cfg_error("cfg_rowmax2", 2, 7);
    test_cfg_error("cfg_colneg", 5, -1);
    test_reset_midframe();
    test_mid_frame_changes();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
